seq_player: RTL and testbench

Upstream sequencer for the 4-bit sequence decoder in the memory-game datapath. On a start request it walks the decoder address from 0 up to a captured round length. Each step is held lit for a programmable number of ticks, then blanked for a gap. It gates the decoder's 4-bit code onto the LED outputs and pulses done when the whole sequence has been shown.

---
 rtl/seq_player_pkg.sv | 17 +
 rtl/seq_tick_timer.sv | 28 ++
 rtl/seq_player.sv | 128 ++++++++++++
 tb/tb_seq_player.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_player_pkg.sv
// Shared types and defaults for the memory-game sequence player.
// State encoding is fixed so the parent datapath can decode it if needed.
package seq_player_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int ADDR_W_DEF    = 4;
  localparam int ON_TICKS_DEF  = 4;
  localparam int OFF_TICKS_DEF = 2;
  localparam int TMR_W_DEF     = 8;

endpackage

// File: rtl/seq_tick_timer.sv
// Tick counter with synchronous clear; term fires on the tick that hits limit.
// Count updates one cycle after tick_en; clear wins over tick_en.
module seq_tick_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             tick_en,
  input  logic [TMR_W-1:0] limit,
  output logic             term
);

  logic [TMR_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick_en) begin
      count <= count + TMR_W'(1);
    end
  end

  assign term = tick_en && (count == limit);

endmodule

// File: rtl/seq_player.sv
// Walks the decoder address 0..round_len, lighting each code then blanking a gap.
// Registered address/lit/done; tick_en=0 pauses the walk, stop aborts to IDLE.
module seq_player
  import seq_player_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ON_TICKS  = ON_TICKS_DEF,
  parameter int OFF_TICKS = OFF_TICKS_DEF,
  parameter int TMR_W     = TMR_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] round_len,
  input  logic              tick_en,
  input  logic [3:0]        seq_code,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        leds,
  output logic              busy,
  output logic              done
);

  localparam logic [TMR_W-1:0] ON_LIM  = TMR_W'(ON_TICKS - 1);
  localparam logic [TMR_W-1:0] OFF_LIM = TMR_W'(OFF_TICKS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] len_q, len_nxt, addr_nxt;
  logic              lit, lit_nxt, done_nxt;
  logic              tmr_clr, tmr_term;
  logic [TMR_W-1:0]  tmr_lim;

  seq_tick_timer #(.TMR_W(TMR_W)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmr_clr),
    .tick_en (tick_en),
    .limit   (tmr_lim),
    .term    (tmr_term)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // stop outranks every timer expiry, so a sequence aborted on its last gap tick never reaches DONE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && !stop) state_nxt = SHOW;
      SHOW: begin
        if (stop)          state_nxt = IDLE;
        else if (tmr_term) state_nxt = GAP;
      end
      GAP: begin
        if (stop)          state_nxt = IDLE;
        else if (tmr_term) state_nxt = (address == len_q) ? DONE : SHOW;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_nxt = address;
    lit_nxt  = lit;
    len_nxt  = len_q;
    done_nxt = (state_nxt == DONE);
    tmr_lim  = (state == GAP) ? OFF_LIM : ON_LIM;
    tmr_clr  = (state_nxt != state) || (state == IDLE) || (state == DONE);
    unique case (state)
      IDLE: begin
        if (state_nxt == SHOW) begin
          len_nxt  = round_len;
          addr_nxt = '0;
          lit_nxt  = 1'b1;
        end
      end
      SHOW: begin
        if (state_nxt == IDLE) begin
          addr_nxt = '0;
          lit_nxt  = 1'b0;
        end else if (state_nxt == GAP) begin
          lit_nxt  = 1'b0;
        end
      end
      GAP: begin
        if (state_nxt == IDLE) begin
          addr_nxt = '0;
          lit_nxt  = 1'b0;
        end else if (state_nxt == SHOW) begin
          addr_nxt = address + ADDR_W'(1);
          lit_nxt  = 1'b1;
        end
      end
      DONE: begin
        addr_nxt = '0;
        lit_nxt  = 1'b0;
      end
      default: begin
        addr_nxt = '0;
        lit_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      address <= '0;
      len_q   <= '0;
      lit     <= 1'b0;
      done    <= 1'b0;
    end else begin
      address <= addr_nxt;
      len_q   <= len_nxt;
      lit     <= lit_nxt;
      done    <= done_nxt;
    end
  end

  assign busy = (state != IDLE);
  assign leds = lit ? seq_code : 4'b0000;

endmodule

// File: tb/tb_seq_player.sv
// Directed bench for seq_player: per-cycle expectations queued at stimulus time,
// popped and compared at each negedge against a behavioural decoder table.
module tb_seq_player;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] leds;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, stop, tick_en;
  logic [3:0] round_len;
  logic [3:0] seq_code;
  logic [3:0] address;
  logic [3:0] leds;
  logic       busy, done;

  int   compared   = 0;
  int   mismatched = 0;
  obs_t expq[$];

  always #5 clock = ~clock;

  function automatic logic [3:0] dec(input logic [3:0] a);
    case (a)
      4'd0: dec = 4'b0001;  4'd1: dec = 4'b0100;  4'd2: dec = 4'b0001;  4'd3: dec = 4'b1000;
      4'd4: dec = 4'b0010;  4'd5: dec = 4'b0100;  4'd6: dec = 4'b1000;  4'd7: dec = 4'b0001;
      4'd8: dec = 4'b0010;  4'd9: dec = 4'b1000;  4'd10: dec = 4'b0100; 4'd11: dec = 4'b0010;
      4'd12: dec = 4'b0001; 4'd13: dec = 4'b0010; 4'd14: dec = 4'b0100; default: dec = 4'b0001;
    endcase
  endfunction

  assign seq_code = dec(address);

  seq_player dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .stop      (stop),
    .round_len (round_len),
    .tick_en   (tick_en),
    .seq_code  (seq_code),
    .address   (address),
    .leds      (leds),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input int c, input logic [3:0] got, input logic [3:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, got, exp);
    end
  endtask

  task automatic chk_obs(input string tag, input int c, input obs_t e);
    chk({tag, ".address"}, c, address, e.addr);
    chk({tag, ".leds"},    c, leds,    e.leds);
    chk({tag, ".busy"},    c, {3'b0, busy}, {3'b0, e.busy});
    chk({tag, ".done"},    c, {3'b0, done}, {3'b0, e.done});
  endtask

  function automatic obs_t idle_obs();
    obs_t o;
    o = '{addr: 4'd0, leds: 4'd0, busy: 1'b0, done: 1'b0};
    return o;
  endfunction

  // Free-running timing: 6 cycles per step (4 lit + 2 gap), done in cycle 1+(len+1)*6.
  function automatic obs_t norm_obs(input int len, input int c);
    obs_t o;
    int   d, s, ph;
    d = 1 + (len + 1) * 6;
    o = idle_obs();
    if (c < d) begin
      s      = (c - 1) / 6;
      ph     = (c - 1) % 6;
      o.addr = 4'(s);
      o.leds = (ph < 4) ? dec(4'(s)) : 4'd0;
      o.busy = 1'b1;
    end else if (c == d) begin
      o.addr = 4'(len);
      o.busy = 1'b1;
      o.done = 1'b1;
    end
    return o;
  endfunction

  // lastc < 0 pushes the whole run plus the first idle cycle after done
  task automatic push_norm(input int len, input int lastc, input int idle_n);
    int n;
    n = (lastc < 0) ? (2 + (len + 1) * 6) : lastc;
    for (int c = 1; c <= n; c++) expq.push_back(norm_obs(len, c));
    for (int i = 0; i < idle_n; i++) expq.push_back(idle_obs());
  endtask

  // mode 1: tick every 3rd cycle, 20-cycle pause in the gap; 2: round_len poked mid-run;
  // 3: start held while busy; 4: stop pulsed in cycle stop_c
  function automatic logic tick_for(input int mode, input int c);
    if (mode != 1) return 1'b1;
    if (c <= 15)   return (c % 3) == 0;
    if (c <= 35)   return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int mode, input int stop_c);
    obs_t e;
    for (int c = 1; expq.size() > 0; c++) begin
      @(negedge clock);
      start   = (mode == 3) && (c >= 8) && (c <= 12);
      stop    = (mode == 4) && (c == stop_c);
      tick_en = tick_for(mode, c);
      if (mode == 2 && c == 7) round_len = 4'd9;
      e = expq.pop_front();
      chk_obs(tag, c, e);
    end
    start   = 1'b0;
    stop    = 1'b0;
    tick_en = 1'b1;
  endtask

  task automatic launch(input logic [3:0] len, input int mode);
    @(negedge clock);
    round_len = len;
    start     = 1'b1;
    stop      = 1'b0;
    tick_en   = tick_for(mode, 0);
  endtask

  initial begin
    obs_t e;
    reset_n   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    tick_en   = 1'b1;
    round_len = 4'd0;
    #1;
    chk_obs("reset", 0, idle_obs());
    #20;
    reset_n = 1'b1;

    // single step, then back-to-back start in the first idle cycle after done
    launch(4'd0, 0);
    push_norm(0, 7, 0);
    drain("len0", 0, 0);
    launch(4'd0, 0);
    push_norm(0, -1, 0);
    drain("len0_b2b", 0, 0);

    // three steps with round_len changed after capture
    launch(4'd2, 2);
    push_norm(2, -1, 0);
    drain("len2", 2, 0);

    // full 16-step round: last lit address 15, done at cycle 97, no wrap
    launch(4'd15, 0);
    push_norm(15, -1, 2);
    drain("len15", 0, 0);

    // slow timebase: 12-cycle SHOW, then the gap frozen for 20 cycles
    launch(4'd0, 1);
    for (int c = 1; c <= 38; c++) begin
      e = idle_obs();
      if (c <= 36) begin
        e.busy = 1'b1;
        e.leds = (c <= 12) ? dec(4'd0) : 4'd0;
      end else if (c == 37) begin
        e.busy = 1'b1;
        e.done = 1'b1;
      end
      expq.push_back(e);
    end
    drain("pause", 1, 0);

    // stop in the gap of address 1: idle next cycle, no done
    launch(4'd3, 4);
    push_norm(3, 11, 9);
    drain("stop_gap", 4, 11);

    // stop on the last gap tick, the edge that would otherwise raise done
    launch(4'd0, 4);
    push_norm(0, 6, 4);
    drain("stop_done", 4, 6);

    // start re-asserted while busy must not restart or disturb the walk
    launch(4'd1, 3);
    push_norm(1, -1, 1);
    drain("start_busy", 3, 0);

    // asynchronous reset while address 3 is lit
    launch(4'd5, 0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("pre_reset.address", 20, address, 4'd3);
    chk("pre_reset.leds", 20, leds, dec(4'd3));
    #2;
    reset_n = 1'b0;
    #1;
    chk_obs("mid_reset", 20, idle_obs());
    @(negedge clock);
    chk_obs("mid_reset_hold", 21, idle_obs());
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) expq.push_back(idle_obs());
    drain("post_reset", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
